// File: rtl/mcdt_nch_if.sv
// Bus bundle for the multi-channel distributor.
// The channel side carries CH_NUM write ports and the output side carries one tagged stream.
// The slave modport is the distributor; the master modport is whoever feeds and drains it.
interface mcdt_nch_if #(
  parameter int CH_NUM     = 4,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 32
);
  localparam int IDW = $clog2(CH_NUM);
  localparam int MW  = $clog2(FIFO_DEPTH) + 1;

  logic [CH_NUM*DW-1:0] ch_data_i;
  logic [CH_NUM-1:0]    ch_valid_i;
  logic [CH_NUM-1:0]    ch_ready_o;
  logic [CH_NUM*MW-1:0] ch_margin_o;
  logic [CH_NUM-1:0]    ch_en_i;
  logic [DW-1:0]        mcdt_data_o;
  logic                 mcdt_val_o;
  logic [IDW-1:0]       mcdt_id_o;
  logic                 mcdt_ready_i;

  modport master (
    output ch_data_i, ch_valid_i, ch_en_i, mcdt_ready_i,
    input  ch_ready_o, ch_margin_o, mcdt_data_o, mcdt_val_o, mcdt_id_o
  );

  modport slave (
    input  ch_data_i, ch_valid_i, ch_en_i, mcdt_ready_i,
    output ch_ready_o, ch_margin_o, mcdt_data_o, mcdt_val_o, mcdt_id_o
  );
endinterface

// File: rtl/mcdt_nch.sv
// Multi-channel data distributor.
// Each channel has its own FIFO. One arbiter drains the FIFOs into a single registered
// output slot, and the slot is tagged with the id of the source channel.
// The arbiter is fixed priority (ARB_MODE 0) or round-robin (ARB_MODE 1).
// A held output word stalls all pops until downstream accepts it.
module mcdt_nch #(
  parameter int CH_NUM     = 4,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int ARB_MODE   = 0
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  mcdt_nch_if.slave  bus
);
  localparam int IDW = $clog2(CH_NUM);
  localparam int MW  = $clog2(FIFO_DEPTH) + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [MW-1:0]  DEPTH_M = MW'(FIFO_DEPTH);
  localparam logic [IDW-1:0] LAST_CH = IDW'(CH_NUM - 1);

  logic [CH_NUM-1:0]         w_elig;
  logic [CH_NUM-1:0]         w_pop;
  logic [CH_NUM-1:0]         w_push;
  logic [CH_NUM-1:0][DW-1:0] w_head;

  logic                      w_slot_free;
  logic                      w_grant_vld;
  logic [IDW-1:0]            w_grant_id;
  logic [IDW-1:0]            r_last_grant;

  logic [DW-1:0]             r_data;
  logic                      r_val;
  logic [IDW-1:0]            r_id;

  // A new word may be loaded when the slot is empty or is being taken this cycle.
  assign w_slot_free = !r_val || bus.mcdt_ready_i;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic [DW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [MW-1:0] r_count;
    logic [MW-1:0] r_margin;
    logic [MW-1:0] w_count_nxt;
    logic          w_full;

    assign w_full    = (r_count == DEPTH_M);
    assign w_push[k] = bus.ch_valid_i[k] && !w_full;
    assign w_pop[k]  = w_grant_vld && (w_grant_id == IDW'(k));
    assign w_elig[k] = (r_count != '0) && bus.ch_en_i[k];
    assign w_head[k] = r_mem[r_rd_ptr];

    assign bus.ch_ready_o[k]            = !w_full;
    assign bus.ch_margin_o[k*MW +: MW]  = r_margin;

    // Occupancy after this edge. A push and a pop in the same cycle cancel out.
    always_comb begin
      w_count_nxt = r_count;
      if (w_push[k] && !w_pop[k]) begin
        w_count_nxt = r_count + MW'(1);
      end else if (!w_push[k] && w_pop[k]) begin
        w_count_nxt = r_count - MW'(1);
      end
    end

    // Storage array, written at the write pointer. The contents need no reset.
    always_ff @(posedge clk_i) begin
      if (w_push[k]) begin
        r_mem[r_wr_ptr] <= bus.ch_data_i[k*DW +: DW];
      end
    end

    // Pointers, occupancy and registered free-entry count.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_margin <= DEPTH_M;
      end else begin
        if (w_push[k]) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop[k]) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        r_count  <= w_count_nxt;
        r_margin <= DEPTH_M - w_count_nxt;
      end
    end
  end

  // Grant selection. Each loop scans from lowest to highest priority,
  // so the last eligible hit wins and no early exit is needed.
  always_comb begin
    int v_idx;
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    v_idx       = 0;
    if (ARB_MODE == 0) begin
      for (int i = CH_NUM - 1; i >= 0; i--) begin
        if (w_elig[IDW'(i)]) begin
          w_grant_vld = 1'b1;
          w_grant_id  = IDW'(i);
        end
      end
    end else begin
      // Offsets CH_NUM down to 1 from last_grant. Offset 1 (the channel just after
      // the previous winner) therefore has the highest priority.
      for (int i = CH_NUM; i >= 1; i--) begin
        v_idx = int'(r_last_grant) + i;
        if (v_idx >= CH_NUM) begin
          v_idx = v_idx - CH_NUM;
        end
        if (w_elig[IDW'(v_idx)]) begin
          w_grant_vld = 1'b1;
          w_grant_id  = IDW'(v_idx);
        end
      end
    end
    if (!w_slot_free) begin
      w_grant_vld = 1'b0;
    end
  end

  // Round-robin history. It moves only when a grant is actually issued.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_last_grant <= LAST_CH;
    end else if (w_grant_vld) begin
      r_last_grant <= w_grant_id;
    end
  end

  // Output slot. It loads the winner's head word. If nothing is eligible it empties,
  // but data and id keep their last value.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_val  <= 1'b0;
      r_data <= '0;
      r_id   <= '0;
    end else if (w_slot_free) begin
      r_val <= w_grant_vld;
      if (w_grant_vld) begin
        r_data <= w_head[w_grant_id];
        r_id   <= w_grant_id;
      end
    end
  end

  assign bus.mcdt_data_o = r_data;
  assign bus.mcdt_val_o  = r_val;
  assign bus.mcdt_id_o   = r_id;

endmodule

// File: tb/tb_mcdt_nch.sv
// Bench for mcdt_nch.
// It runs two instances side by side on the same stimulus:
// u_dut0 uses fixed priority and u_dut1 uses round-robin.
// A queue-based reference model predicts both instances.
`timescale 1ns/1ps
module tb_mcdt_nch;
  localparam int CH    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int MW    = 6;
  localparam int IDW   = 2;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;

  logic [CH*DW-1:0] t_data  = '0;
  logic [CH-1:0]    t_valid = '0;
  logic [CH-1:0]    t_en    = '0;
  logic             t_rdy   = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  mcdt_nch_if #(.CH_NUM(CH), .DW(DW), .FIFO_DEPTH(DEPTH)) if0 ();
  mcdt_nch_if #(.CH_NUM(CH), .DW(DW), .FIFO_DEPTH(DEPTH)) if1 ();

  assign if0.ch_data_i    = t_data;
  assign if0.ch_valid_i   = t_valid;
  assign if0.ch_en_i      = t_en;
  assign if0.mcdt_ready_i = t_rdy;
  assign if1.ch_data_i    = t_data;
  assign if1.ch_valid_i   = t_valid;
  assign if1.ch_en_i      = t_en;
  assign if1.mcdt_ready_i = t_rdy;

  mcdt_nch #(.CH_NUM(CH), .DW(DW), .FIFO_DEPTH(DEPTH), .ARB_MODE(0)) u_dut0 (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .bus   (if0)
  );

  mcdt_nch #(.CH_NUM(CH), .DW(DW), .FIFO_DEPTH(DEPTH), .ARB_MODE(1)) u_dut1 (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .bus   (if1)
  );

  always #5 clk_i = ~clk_i;

  logic [1:0]                o_val;
  logic [1:0][DW-1:0]        o_data;
  logic [1:0][IDW-1:0]       o_id;
  logic [1:0][CH-1:0]        o_rdy;
  logic [1:0][CH*MW-1:0]     o_mar;

  assign o_val[0]  = if0.mcdt_val_o;
  assign o_val[1]  = if1.mcdt_val_o;
  assign o_data[0] = if0.mcdt_data_o;
  assign o_data[1] = if1.mcdt_data_o;
  assign o_id[0]   = if0.mcdt_id_o;
  assign o_id[1]   = if1.mcdt_id_o;
  assign o_rdy[0]  = if0.ch_ready_o;
  assign o_rdy[1]  = if1.ch_ready_o;
  assign o_mar[0]  = if0.ch_margin_o;
  assign o_mar[1]  = if1.ch_margin_o;

  function automatic int mar(int m, int k);
    return int'(o_mar[m][k*MW +: MW]);
  endfunction

  // Reference model. mq[m*CH+k] is the FIFO contents of channel k in instance m.
  logic [DW-1:0] mq [2*CH][$];
  bit            m_val  [2];
  logic [DW-1:0] m_data [2];
  int            m_id   [2];
  int            m_last [2];

  task automatic model_reset();
    for (int i = 0; i < 2*CH; i++) mq[i].delete();
    for (int m = 0; m < 2; m++) begin
      m_val[m]  = 1'b0;
      m_data[m] = '0;
      m_id[m]   = 0;
      m_last[m] = CH - 1;
    end
  endtask

  task automatic model_edge();
    bit acc [CH];
    bit elig [CH];
    bit free;
    int g;
    int c;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < CH; k++) begin
        acc[k]  = t_valid[k] && (mq[m*CH+k].size() < DEPTH);
        elig[k] = (mq[m*CH+k].size() != 0) && t_en[k];
      end
      free = !m_val[m] || t_rdy;
      g = -1;
      if (free) begin
        for (int i = 0; i < CH; i++) begin
          c = (m == 0) ? i : (m_last[m] + 1 + i) % CH;
          if (g < 0 && elig[c]) g = c;
        end
        if (g >= 0) begin
          m_data[m] = mq[m*CH+g].pop_front();
          m_id[m]   = g;
          m_val[m]  = 1'b1;
          m_last[m] = g;
        end else begin
          m_val[m] = 1'b0;
        end
      end
      for (int k = 0; k < CH; k++)
        if (acc[k]) mq[m*CH+k].push_back(t_data[k*DW +: DW]);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    if (rstn_i) model_edge();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rstn_i  = 1'b0;
    t_valid = '0;
    t_en    = '0;
    t_rdy   = 1'b1;
    t_data  = '0;
    model_reset();
    step();
    step();
    rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    do_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < CH; k++) begin
        n_vec++;
        if (mar(m, k) !== DEPTH) begin
          n_err++;
          $display("FAIL reset_margin dut%0d ch%0d: got %0d exp %0d", m, k, mar(m, k), DEPTH);
        end
      end
      n_vec++;
      if (o_rdy[m] !== 4'hF) begin
        n_err++;
        $display("FAIL reset_ready dut%0d: got %h exp F", m, o_rdy[m]);
      end
      n_vec++;
      if (o_val[m] !== 1'b0 || o_data[m] !== '0 || o_id[m] !== '0) begin
        n_err++;
        $display("FAIL reset_out dut%0d: got val=%b data=%h id=%0d exp 0/0/0", m, o_val[m], o_data[m], o_id[m]);
      end
    end
  endtask

  task automatic test_latency();
    t_en  = 4'hF;
    t_rdy = 1'b1;
    t_data[2*DW +: DW] = 32'hA5A5_0001;
    t_valid = 4'b0100;
    step();
    t_valid = '0;
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (o_val[m] !== 1'b0 || mar(m, 2) !== DEPTH - 1) begin
        n_err++;
        $display("FAIL lat_n1 dut%0d: got val=%b margin=%0d exp 0/%0d", m, o_val[m], mar(m, 2), DEPTH - 1);
      end
    end
    step();
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (o_val[m] !== 1'b1 || o_data[m] !== 32'hA5A5_0001 || o_id[m] !== 2'd2) begin
        n_err++;
        $display("FAIL lat_n2 dut%0d: got val=%b data=%h id=%0d exp 1/a5a50001/2", m, o_val[m], o_data[m], o_id[m]);
      end
    end
    step();
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (o_val[m] !== 1'b0) begin
        n_err++;
        $display("FAIL lat_n3 dut%0d: got val=%b exp 0", m, o_val[m]);
      end
    end
  endtask

  task automatic test_full();
    int cnt [2];
    do_reset();
    t_en    = 4'b1101;
    t_rdy   = 1'b1;
    t_valid = 4'b0010;
    for (int i = 0; i <= DEPTH; i++) begin
      t_data[1*DW +: DW] = 32'h1000_0000 + 32'(i);
      step();
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (mar(m, 1) !== ((i + 1 < DEPTH) ? DEPTH - i - 1 : 0) ||
            o_rdy[m][1] !== (i + 1 < DEPTH) || o_val[m] !== 1'b0) begin
          n_err++;
          $display("FAIL full_fill dut%0d push%0d: got margin=%0d rdy=%b val=%b", m, i, mar(m, 1), o_rdy[m][1], o_val[m]);
        end
      end
    end
    t_valid = '0;
    t_en    = 4'hF;
    cnt[0] = 0;
    cnt[1] = 0;
    for (int s = 0; s < DEPTH + 8; s++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        if (o_val[m]) begin
          n_vec++;
          if (o_id[m] !== 2'd1 || o_data[m] !== 32'h1000_0000 + 32'(cnt[m])) begin
            n_err++;
            $display("FAIL full_drain dut%0d word%0d: got id=%0d data=%h exp 1/%h", m, cnt[m], o_id[m], o_data[m], 32'h1000_0000 + 32'(cnt[m]));
          end
          cnt[m]++;
        end
      end
    end
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (cnt[m] != DEPTH || mar(m, 1) !== DEPTH) begin
        n_err++;
        $display("FAIL full_count dut%0d: got words=%0d margin=%0d exp %0d/%0d", m, cnt[m], mar(m, 1), DEPTH, DEPTH);
      end
    end
  endtask

  task automatic test_arb();
    int qid [2][$];
    int exp_ids [2][8];
    exp_ids[0] = '{0, 0, 1, 1, 2, 2, 3, 3};
    exp_ids[1] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    t_rdy   = 1'b1;
    t_en    = '0;
    t_valid = 4'hF;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < CH; k++) t_data[k*DW +: DW] = 32'h3000_0000 + 32'(k*16 + c);
      step();
    end
    t_valid = '0;
    t_en    = 4'hF;
    for (int s = 0; s < 12; s++) begin
      step();
      for (int m = 0; m < 2; m++) if (o_val[m]) qid[m].push_back(int'(o_id[m]));
    end
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (qid[m].size() != 8) begin
        n_err++;
        $display("FAIL arb_len dut%0d: got %0d exp 8", m, qid[m].size());
      end else begin
        for (int i = 0; i < 8; i++) begin
          n_vec++;
          if (qid[m][i] != exp_ids[m][i]) begin
            n_err++;
            $display("FAIL arb_seq dut%0d pos%0d: got id %0d exp %0d", m, i, qid[m][i], exp_ids[m][i]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int idx [2][CH];
    logic [DW-1:0] h_data [2];
    logic [IDW-1:0] h_id [2];
    int h_mar [2][CH];
    do_reset();
    t_rdy   = 1'b1;
    t_en    = '0;
    t_valid = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      t_data[0*DW +: DW] = 32'h4000_0000 + 32'(i);
      t_data[2*DW +: DW] = 32'h4200_0000 + 32'(i);
      step();
    end
    t_valid = '0;
    t_en    = 4'hF;
    for (int m = 0; m < 2; m++) for (int k = 0; k < CH; k++) idx[m][k] = 0;
    step();
    for (int m = 0; m < 2; m++) begin
      h_data[m] = o_data[m];
      h_id[m]   = o_id[m];
      for (int k = 0; k < CH; k++) h_mar[m][k] = mar(m, k);
      n_vec++;
      if (o_val[m] !== 1'b1 || o_data[m] !== 32'h4000_0000 + 32'(int'(o_id[m]) << 24)) begin
        n_err++;
        $display("FAIL bp_first dut%0d: got val=%b data=%h id=%0d", m, o_val[m], o_data[m], o_id[m]);
      end
      idx[m][o_id[m]]++;
    end
    t_rdy = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (o_val[m] !== 1'b1 || o_data[m] !== h_data[m] || o_id[m] !== h_id[m]) begin
          n_err++;
          $display("FAIL bp_hold dut%0d cyc%0d: got val=%b data=%h id=%0d exp 1/%h/%0d", m, s, o_val[m], o_data[m], o_id[m], h_data[m], h_id[m]);
        end
        for (int k = 0; k < CH; k++) begin
          n_vec++;
          if (mar(m, k) !== h_mar[m][k]) begin
            n_err++;
            $display("FAIL bp_margin dut%0d ch%0d: got %0d exp %0d", m, k, mar(m, k), h_mar[m][k]);
          end
        end
      end
    end
    t_rdy = 1'b1;
    for (int s = 0; s < 10; s++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        if (o_val[m]) begin
          n_vec++;
          if (o_data[m] !== 32'h4000_0000 + 32'((int'(o_id[m]) << 24) + idx[m][o_id[m]])) begin
            n_err++;
            $display("FAIL bp_order dut%0d: got data=%h id=%0d exp seq %0d", m, o_data[m], o_id[m], idx[m][o_id[m]]);
          end
          idx[m][o_id[m]]++;
        end
      end
    end
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (idx[m][0] != 3 || idx[m][2] != 3) begin
        n_err++;
        $display("FAIL bp_count dut%0d: got ch0=%0d ch2=%0d exp 3/3", m, idx[m][0], idx[m][2]);
      end
    end
  endtask

  task automatic test_pushpop_reset();
    do_reset();
    t_rdy   = 1'b1;
    t_en    = 4'b1110;
    t_valid = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      t_data[0 +: DW] = 32'h5000_0000 + 32'(i);
      step();
    end
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (mar(m, 0) !== 16) begin
        n_err++;
        $display("FAIL pp_fill dut%0d: got margin %0d exp 16", m, mar(m, 0));
      end
    end
    t_en = 4'hF;
    for (int i = 16; i < 22; i++) begin
      t_data[0 +: DW] = 32'h5000_0000 + 32'(i);
      step();
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (mar(m, 0) !== 16 || o_val[m] !== 1'b1) begin
          n_err++;
          $display("FAIL pp_steady dut%0d push%0d: got margin=%0d val=%b exp 16/1", m, i, mar(m, 0), o_val[m]);
        end
      end
    end
    #1;
    rstn_i = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < CH; k++) begin
        n_vec++;
        if (mar(m, k) !== DEPTH) begin
          n_err++;
          $display("FAIL rst_mid_margin dut%0d ch%0d: got %0d exp %0d", m, k, mar(m, k), DEPTH);
        end
      end
      n_vec++;
      if (o_val[m] !== 1'b0 || o_data[m] !== '0) begin
        n_err++;
        $display("FAIL rst_mid_out dut%0d: got val=%b data=%h exp 0/0", m, o_val[m], o_data[m]);
      end
    end
    model_reset();
    t_valid = '0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (o_val[m] !== 1'b0 || mar(m, 0) !== DEPTH) begin
          n_err++;
          $display("FAIL rst_mid_stale dut%0d cyc%0d: got val=%b margin=%0d exp 0/%0d", m, s, o_val[m], mar(m, 0), DEPTH);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < CH; k++) begin
        t_data[k*DW +: DW] = $urandom;
        t_valid[k] = 1'($urandom_range(0, 1));
        t_en[k]    = ($urandom_range(0, 7) != 0);
      end
      t_rdy = ($urandom_range(0, 3) != 0);
      step();
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (o_val[m] !== m_val[m] || o_data[m] !== m_data[m] || o_id[m] !== IDW'(m_id[m])) begin
          n_err++;
          $display("FAIL rnd_out dut%0d cyc%0d: got %b/%h/%0d exp %b/%h/%0d", m, cyc, o_val[m], o_data[m], o_id[m], m_val[m], m_data[m], m_id[m]);
        end
        for (int k = 0; k < CH; k++) begin
          n_vec++;
          if (mar(m, k) !== DEPTH - mq[m*CH+k].size() || o_rdy[m][k] !== (mq[m*CH+k].size() != DEPTH)) begin
            n_err++;
            $display("FAIL rnd_fifo dut%0d ch%0d cyc%0d: got margin=%0d rdy=%b exp margin=%0d", m, k, cyc, mar(m, k), o_rdy[m][k], DEPTH - mq[m*CH+k].size());
          end
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_full();
    test_arb();
    test_backpressure();
    test_pushpop_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
